// File: rtl/data_dly_var_pkg.sv
// Shared types and helpers for the variable-length priming delay line.
package data_dly_var_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } dly_state_t;

  // Priming length of 0 behaves as 1; anything above the buffer depth saturates.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/dti_s_if.sv
// DTI stream bundle: data plus valid/ready handshake.
interface dti_s_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dly_cbuf.sv
// Circular buffer: MAX_LEN entries, wrap-around pointers, registered item count.
// Read data is mem[rd_ptr] with no output register; storage is not reset.
module dly_cbuf
  import data_dly_var_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int W_DIN   = 16,
  parameter int W_LEN   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W_DIN-1:0] wr_data,
  output logic [W_DIN-1:0] rd_data,
  output logic [W_LEN-1:0] count,
  output logic [W_LEN-1:0] count_nxt,
  output logic             full,
  output logic             empty
);

  localparam int W_PTR = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [W_DIN-1:0] mem [MAX_LEN];
  logic [W_PTR-1:0] wr_ptr;
  logic [W_PTR-1:0] rd_ptr;

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + W_LEN'(1);
    else if (pop && !push) count_nxt = count - W_LEN'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= (wr_ptr == W_PTR'(MAX_LEN - 1)) ? '0 : wr_ptr + W_PTR'(1);
      if (pop)  rd_ptr <= (rd_ptr == W_PTR'(MAX_LEN - 1)) ? '0 : rd_ptr + W_PTR'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == W_LEN'(MAX_LEN));
  assign empty   = (count == '0);

endmodule

// File: rtl/data_dly_var.sv
// Priming delay line: holds DTI items until cfg_len have arrived, then streams until empty.
// dout.valid rises the cycle after the cfg_len-th push; din.ready drops when full or draining.
// DATA_DLY_VAR_FLUSH_EN adds the flush port and the DRAIN state.
module data_dly_var
  import data_dly_var_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int W_DIN   = 16,
  localparam int W_LEN   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_LEN-1:0] cfg_len,
`ifdef DATA_DLY_VAR_FLUSH_EN
  input  logic             flush,
`endif
  dti_s_if.consumer        din,
  dti_s_if.producer        dout,
  output logic [W_LEN-1:0] occupancy,
  output logic             primed
);

  dly_state_t       state, state_nxt;
  logic             push, pop, full, empty;
  logic             din_rdy, dout_vld;
  logic [W_LEN-1:0] count, count_nxt;
  logic [W_LEN-1:0] len_q, len_eff, cfg_clamped;

  assign cfg_clamped = W_LEN'(clamp_len(int'(cfg_len), MAX_LEN));
  // In IDLE the live config decides the very first transition, matching what len_q latches.
  assign len_eff     = (state == IDLE) ? cfg_clamped : len_q;

  assign din_rdy  = !full && (state != DRAIN);
  assign dout_vld = ((state == RUN) || (state == DRAIN)) && !empty;
  assign push     = din.valid && din_rdy;
  assign pop      = dout_vld && dout.ready;

  assign din.ready  = din_rdy;
  assign dout.valid = dout_vld;
  assign occupancy  = count;
  assign primed     = (state == RUN) || (state == DRAIN);

  dly_cbuf #(
    .MAX_LEN (MAX_LEN),
    .W_DIN   (W_DIN),
    .W_LEN   (W_LEN)
  ) u_cbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wr_data   (din.data),
    .rd_data   (dout.data),
    .count     (count),
    .count_nxt (count_nxt),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (push) state_nxt = (count_nxt >= len_eff) ? RUN : FILL;
      end
      FILL: begin
        if (count_nxt >= len_eff) state_nxt = RUN;
`ifdef DATA_DLY_VAR_FLUSH_EN
        if (flush) state_nxt = DRAIN;
`endif
      end
      RUN: begin
`ifdef DATA_DLY_VAR_FLUSH_EN
        if (flush) state_nxt = DRAIN;
`endif
        // Running empty wins over a coincident flush: nothing is left to drain.
        if (count_nxt == '0) state_nxt = IDLE;
      end
      DRAIN: begin
        if (count_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      len_q <= W_LEN'(1);
    end else begin
      state <= state_nxt;
      if (state == IDLE) len_q <= cfg_clamped;
    end
  end

endmodule

// File: doc/data_dly_var.md
# data_dly_var

Runtime-configurable, handshake-aware priming delay line for DTI streams. Incoming transfers are buffered until `cfg_len` items have accumulated. The buffer then streams them out until it runs empty, after which it re-primes. It is a circular-buffer successor to the fixed-length register-chain delay and adds a runtime length, an occupancy status and an optional flush. It sits between any DTI producer/consumer pair that needs item-count alignment, e.g. FIR tap alignment or frame-lag compensation.

## Interface
- `MAX_LEN`, 8, buffer depth and maximum priming length (≥1).
- `W_DIN`, 16, data width of `din`/`dout`.
- `W_LEN`, `$clog2(MAX_LEN+1)`, width of length/occupancy fields (derived, not overridden).

- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cfg_len` input W_LEN: priming threshold; sampled only in IDLE.
- `flush` input 1: single-cycle request to release buffered items without reaching threshold (only with `DATA_DLY_VAR_FLUSH_EN`).
- `din` `dti_s_if.consumer` W_DIN: input stream (data/valid/ready).
- `dout` `dti_s_if.producer` W_DIN: output stream.
- `occupancy` output W_LEN: current item count.
- `primed` output 1: high in RUN or DRAIN.

## Operation
- Storage: MAX_LEN × W_DIN circular buffer. `wr_ptr`, `rd_ptr` wrap from MAX_LEN-1 to 0. `count` ranges 0..MAX_LEN.
- Effective length `len_q` is latched from `cfg_len` on every IDLE cycle.
  - 0 is treated as 1.
  - Values above MAX_LEN clamp to MAX_LEN.
- Push = `din.valid && din.ready`. Pop = `dout.valid && dout.ready`. Simultaneous push and pop leave `count` unchanged.
- `din.ready` = (`count != MAX_LEN`) and state ≠ DRAIN. There is no same-cycle full bypass.
- `dout.valid` = state ∈ {RUN, DRAIN} and `count != 0`. `dout.data` = `mem[rd_ptr]`.
- States:
  - IDLE: `count==0`. Enter FILL on push, or go directly to RUN if `len_q==1`.
  - FILL: output withheld. Go to RUN when `count_next >= len_q`. Go to DRAIN on `flush` (if enabled).
  - RUN: stream out and keep accepting while not full. Go to IDLE when `count_next==0`. Go to DRAIN on `flush`.
  - DRAIN: input blocked, output enabled. Go to IDLE when `count_next==0`.
- `flush` in IDLE is ignored. `flush` in DRAIN has no effect.
- A change to `cfg_len` outside IDLE has no effect until the next IDLE.
- Reset values:
  - `state`=IDLE; `count`, `wr_ptr`, `rd_ptr` = 0; `len_q`=1.
  - `dout.valid`=0, `din.ready`=1, `occupancy`=0, `primed`=0.
  - Memory contents are not reset.

## Timing
- State, pointers and `count` are registered. `dout.valid`, `din.ready` and `primed` are decoded combinationally from registered state only; there is no `din`→`dout` combinational path.
- Latency: `dout.valid` rises the cycle after the edge that completes the `len_q`-th push.
- Throughput in RUN is 1 item/cycle with `dout.ready` held high.
- Reset mid-operation clears outputs asynchronously. Buffered items are discarded.
- Full with `dout.ready` high: push is refused that cycle and accepted the next.

## Configuration
- `DATA_DLY_VAR_FLUSH_EN` defined: the `flush` port and the DRAIN state exist as above.
- Undefined: no `flush` port and no DRAIN state. A partially filled buffer holds until the threshold is reached.

## Structure
- `data_dly_var_pkg`: `dly_state_t` enum {IDLE, FILL, RUN, DRAIN}, and a `clamp_len` function (0→1, >MAX_LEN→MAX_LEN).
- Sub-module `dly_cbuf`: circular buffer holding memory, pointers and `count`, with push/pop inputs and full/empty/count outputs. The top level holds the FSM and handshake decode.

## Test plan
- Prime and stream, `MAX_LEN=8`, `cfg_len=3`, `dout.ready`=1:
  - Push 0x11, 0x22, 0x33, 0x44 back-to-back.
  - `dout.valid` stays 0 until the cycle after the 0x33 push, then 0x11..0x44 appear in order.
  - `occupancy` peaks at 3; FSM ends in IDLE.
- Backpressure to full, `cfg_len=2`, `dout.ready`=0:
  - Push 9 items.
  - `din.ready` drops after the 8th push and `occupancy`=8.
  - Raising `dout.ready` drains all 8 in order.
- Clamp, `cfg_len=0` and `cfg_len=15`:
  - 0 gives output the cycle after the first push.
  - 15 behaves as 8.
- Flush (macro on), `cfg_len=5`:
  - Push 2 items, then pulse `flush`.
  - Both items emerge, `din.ready`=0 during DRAIN, then IDLE.
  - With the macro off, the same stimulus emits nothing.
- Async reset:
  - Assert `rst`=0 mid-RUN with `occupancy`=4.
  - `dout.valid`, `primed` and `occupancy` go to 0 without a clock edge.
  - After release, priming restarts from empty.
